throughout_goto_monitor: RTL and testbench

- Synthesizable runtime checker for the property "after trig rises, hold must stay high throughout COUNT (not necessarily consecutive) cycles of evt". It is the hardware equivalent of `$rose(trig) |=> (hold throughout evt[->COUNT])` with `disable iff (reset)`.
- Used on-chip or in simulation benches next to the pattern-driven stimulus generators. It reports per-attempt pass/fail events and running totals.
- Overlapping attempts are tracked in independent slots.

---
 rtl/throughout_goto_monitor.sv | 144 ++++++++++++++
 tb/tb_throughout_goto_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/throughout_goto_monitor.sv
// throughout_goto_monitor: runtime checker for
// $rose(trig) |=> (hold throughout evt[->COUNT]), one slot per outstanding attempt.
module throughout_goto_monitor #(
  parameter int COUNT     = 3,
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           trig,
  input  logic                           hold,
  input  logic                           evt,
  output logic                           pass,
  output logic                           fail,
  output logic                           overflow,
  output logic [$clog2(NUM_SLOTS+1)-1:0] active,
  output logic [CNT_W-1:0]               pass_count,
  output logic [CNT_W-1:0]               fail_count
);

  localparam int AW = $clog2(NUM_SLOTS + 1);
  localparam int CW = $clog2(COUNT + 1);
  localparam int SW = ((CNT_W > AW) ? CNT_W : AW) + 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic {
    IDLE,
    ARMED
  } slot_t;

  slot_t          st    [NUM_SLOTS];
  slot_t          st_n  [NUM_SLOTS];
  logic [CW-1:0]  cnt   [NUM_SLOTS];
  logic [CW-1:0]  cnt_n [NUM_SLOTS];

  logic                 trig_prev;
  logic                 rise;
  logic                 placed;
  logic                 drop;
  logic [NUM_SLOTS-1:0] done_ok;
  logic [NUM_SLOTS-1:0] done_bad;
  logic [AW-1:0]        n_ok;
  logic [AW-1:0]        n_bad;
  logic [AW-1:0]        n_busy;
  logic [CNT_W-1:0]     pass_count_n;
  logic [CNT_W-1:0]     fail_count_n;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [AW-1:0]    b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_W{1'b1}}))
      return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  assign rise = trig & ~trig_prev;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
    end
    done_ok  = '0;
    done_bad = '0;
    placed   = 1'b0;
    drop     = 1'b0;
    n_ok     = '0;
    n_bad    = '0;
    n_busy   = '0;

    // hold low wins over a completing evt in the same cycle
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st[i] == ARMED) begin
        if (!hold) begin
          done_bad[i] = 1'b1;
          st_n[i]     = IDLE;
        end else if (evt) begin
          if (cnt[i] == LAST) begin
            done_ok[i] = 1'b1;
            st_n[i]    = IDLE;
          end else begin
            cnt_n[i] = cnt[i] + CW'(1);
          end
        end
      end
    end

    // slots freed this cycle are already eligible for a new attempt
    if (rise) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!placed && st_n[i] == IDLE) begin
          st_n[i]  = ARMED;
          cnt_n[i] = '0;
          placed   = 1'b1;
        end
      end
      drop = ~placed;
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (done_ok[i])
        n_ok = n_ok + AW'(1);
      if (done_bad[i])
        n_bad = n_bad + AW'(1);
      if (st_n[i] == ARMED)
        n_busy = n_busy + AW'(1);
    end

    pass_count_n = sat_add(pass_count, n_ok);
    fail_count_n = sat_add(fail_count, n_bad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      trig_prev  <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      overflow   <= 1'b0;
      active     <= '0;
      pass_count <= '0;
      fail_count <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      trig_prev  <= trig;
      pass       <= |done_ok;
      fail       <= |done_bad;
      overflow   <= drop;
      active     <= n_busy;
      pass_count <= pass_count_n;
      fail_count <= fail_count_n;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]  <= st_n[i];
        cnt[i] <= cnt_n[i];
      end
    end
  end

endmodule

// File: tb/tb_throughout_goto_monitor.sv
// tb_throughout_goto_monitor: directed vectors for a 4-slot/16-bit monitor
// and a 1-slot/2-bit monitor driven by the same stimulus.
module tb_throughout_goto_monitor;

  logic        clock;
  logic        reset;
  logic        trig;
  logic        hold;
  logic        evt;

  logic        pa, fa, oa;
  logic [2:0]  acta;
  logic [15:0] pca, fca;

  logic        pb, fb, ob;
  logic [0:0]  actb;
  logic [1:0]  pcb, fcb;

  int n_checks;
  int n_fail;

  throughout_goto_monitor #(
    .COUNT(3), .NUM_SLOTS(4), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset(reset), .trig(trig),
    .hold(hold), .evt(evt),
    .pass(pa), .fail(fa), .overflow(oa),
    .active(acta), .pass_count(pca), .fail_count(fca)
  );

  throughout_goto_monitor #(
    .COUNT(3), .NUM_SLOTS(1), .CNT_W(2)
  ) dut_b (
    .clock(clock), .reset(reset), .trig(trig),
    .hold(hold), .evt(evt),
    .pass(pb), .fail(fb), .overflow(ob),
    .active(actb), .pass_count(pcb), .fail_count(fcb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic r, t, h, e;
    logic p, f, o;
    int   act, pc, fc;
    logic b;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(
    input logic r, input logic t, input logic h, input logic e,
    input logic p, input logic f, input logic o,
    input int act, input int pc, input int fc, input logic b
  );
    vec_t v;
    v = '{r: r, t: t, h: h, e: e, p: p, f: f, o: o,
          act: act, pc: pc, fc: fc, b: b};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic t,
                      input logic h, input logic e);
    reset = r;
    trig  = t;
    hold  = h;
    evt   = e;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    trig  = 1'b0;
    hold  = 1'b0;
    evt   = 1'b0;

    // generator patterns, cycles 0-19
    addv(1,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,1,0,0, 0,0,0, 1,0,0, 1);
    addv(0,1,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,0, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 1,0,0, 0,1,0, 1);
    addv(0,0,0,0, 0,0,0, 0,1,0, 1);
    addv(0,1,0,0, 0,0,0, 1,1,0, 1);
    addv(0,0,1,0, 0,0,0, 1,1,0, 1);
    addv(1,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,1,0,1, 0,0,0, 1,0,0, 1);
    addv(0,1,1,0, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,0, 0,0,0, 1,0,0, 1);
    addv(0,0,0,1, 0,1,0, 0,0,1, 1);
    addv(0,0,1,0, 0,0,0, 0,0,1, 1);
    addv(0,0,0,0, 0,0,0, 0,0,1, 1);
    addv(0,0,0,0, 0,0,0, 0,0,1, 1);
    // simple pass
    addv(1,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,1,0,0, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 1,0,0, 0,1,0, 1);
    addv(0,0,0,0, 0,0,0, 0,1,0, 1);
    // hold drops on the completing evt
    addv(1,0,0,0, 0,0,0, 0,0,0, 1);
    addv(0,1,0,0, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,1,1, 0,0,0, 1,0,0, 1);
    addv(0,0,0,1, 0,1,0, 0,0,1, 1);
    addv(0,0,0,0, 0,0,0, 0,0,1, 1);
    // five rises into four slots, then a 4-way pass
    addv(1,0,0,0, 0,0,0, 0,0,0, 0);
    addv(0,1,1,0, 0,0,0, 1,0,0, 0);
    addv(0,0,1,0, 0,0,0, 1,0,0, 0);
    addv(0,1,1,0, 0,0,0, 2,0,0, 0);
    addv(0,0,1,0, 0,0,0, 2,0,0, 0);
    addv(0,1,1,0, 0,0,0, 3,0,0, 0);
    addv(0,0,1,0, 0,0,0, 3,0,0, 0);
    addv(0,1,1,0, 0,0,0, 4,0,0, 0);
    addv(0,0,1,0, 0,0,0, 4,0,0, 0);
    addv(0,1,1,0, 0,0,1, 4,0,0, 0);
    addv(0,0,1,0, 0,0,0, 4,0,0, 0);
    addv(0,0,1,1, 0,0,0, 4,0,0, 0);
    addv(0,0,1,1, 0,0,0, 4,0,0, 0);
    addv(0,0,1,1, 1,0,0, 0,4,0, 0);
    addv(0,0,0,0, 0,0,0, 0,4,0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].h, vecs[i].e);
      chk($sformatf("v%0d a.pass", i), 32'(pa), 32'(vecs[i].p));
      chk($sformatf("v%0d a.fail", i), 32'(fa), 32'(vecs[i].f));
      chk($sformatf("v%0d a.ovf", i), 32'(oa), 32'(vecs[i].o));
      chk($sformatf("v%0d a.active", i), 32'(acta), vecs[i].act);
      chk($sformatf("v%0d a.pass_count", i), 32'(pca), vecs[i].pc);
      chk($sformatf("v%0d a.fail_count", i), 32'(fca), vecs[i].fc);
      if (vecs[i].b) begin
        chk($sformatf("v%0d b.pass", i), 32'(pb), 32'(vecs[i].p));
        chk($sformatf("v%0d b.fail", i), 32'(fb), 32'(vecs[i].f));
        chk($sformatf("v%0d b.ovf", i), 32'(ob), 32'(vecs[i].o));
        chk($sformatf("v%0d b.active", i), 32'(actb), vecs[i].act);
        chk($sformatf("v%0d b.pass_count", i), 32'(pcb), vecs[i].pc);
        chk($sformatf("v%0d b.fail_count", i), 32'(fcb), vecs[i].fc);
      end
    end

    // saturation of the 2-bit total
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 0);
      chk($sformatf("sat%0d b.active", k), 32'(actb), 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk($sformatf("sat%0d a.pass", k), 32'(pa), 1);
      chk($sformatf("sat%0d b.pass", k), 32'(pb), 1);
      chk($sformatf("sat%0d a.pass_count", k), 32'(pca), k + 1);
      chk($sformatf("sat%0d b.pass_count", k), 32'(pcb),
          (k + 1 > 3) ? 3 : k + 1);
    end

    // completion and new rise in the same cycle reuse the slot
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    chk("reuse b.pass", 32'(pb), 1);
    chk("reuse b.ovf", 32'(ob), 0);
    chk("reuse b.active", 32'(actb), 1);
    chk("reuse a.active", 32'(acta), 1);
    step(0, 0, 1, 1);
    chk("reuse1 b.pass", 32'(pb), 0);
    chk("reuse1 b.active", 32'(actb), 1);
    step(0, 0, 1, 1);
    chk("reuse2 b.active", 32'(actb), 1);
    step(0, 0, 1, 1);
    chk("reuse3 b.pass", 32'(pb), 1);
    chk("reuse3 b.active", 32'(actb), 0);
    chk("reuse3 b.pass_count", 32'(pcb), 2);
    chk("reuse3 b.ovf", 32'(ob), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
